kogge_stone_pipe: RTL and testbench

//  Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready handshake.

---
 rtl/kogge_stone_if.sv | 27 ++
 rtl/kogge_stone_pipe.sv | 174 +++++++++++++++++
 tb/tb_kogge_stone_pipe.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/kogge_stone_if.sv
// Stream interface for the pipelined Kogge-Stone adder/subtractor.
// The master side drives operands and out_ready; the slave side returns results.
interface kogge_stone_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// Latency is 2 + ceil($clog2(N)/PIPE_EVERY) cycles; the whole pipe stalls as one.
module kogge_stone_pipe #(
    parameter int N          = 16,
    parameter int PIPE_EVERY = 1
) (
    input  logic          clk,
    input  logic          rst,
    kogge_stone_if.slave  io
);
    localparam int LEVELS = $clog2(N);

    logic adv;
    logic out_valid_reg;

    assign adv          = ~out_valid_reg | io.out_ready;
    assign io.in_ready  = adv;
    assign io.out_valid = out_valid_reg;

    // ------------------------------------------------------------------
    // Stage 1: operand conditioning, bitwise generate/propagate
    // ------------------------------------------------------------------
    logic [N-1:0] bm_next;
    logic [N-1:0] s1_g_reg;
    logic [N-1:0] s1_p_reg;
    logic         s1_c0_reg;
    logic         s1_valid_reg;

    assign bm_next = io.sub ? ~io.b : io.b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_g_reg     <= '0;
            s1_p_reg     <= '0;
            s1_c0_reg    <= 1'b0;
        end else if (adv) begin
            s1_valid_reg <= io.in_valid;
            s1_g_reg     <= io.a & bm_next;
            s1_p_reg     <= io.a ^ bm_next;
            // Subtraction forces the +1 of the two's complement, so cin is ignored.
            s1_c0_reg    <= io.sub | io.cin;
        end
    end

    // ------------------------------------------------------------------
    // Prefix tree. Element k holds the group signals entering level k.
    // Group propagate is not needed after the last level.
    // ------------------------------------------------------------------
    logic [N-1:0] lvl_g  [0:LEVELS];
    logic [N-1:0] lvl_p  [0:LEVELS-1];
    logic [N-1:0] lvl_po [0:LEVELS];
    logic         lvl_c0 [0:LEVELS];
    logic         lvl_v  [0:LEVELS];

    // Carry-in folded into bit 0 so G_i becomes the true carry out of bit i.
    assign lvl_g[0]  = {s1_g_reg[N-1:1], s1_g_reg[0] | (s1_p_reg[0] & s1_c0_reg)};
    assign lvl_p[0]  = s1_p_reg;
    assign lvl_po[0] = s1_p_reg;
    assign lvl_c0[0] = s1_c0_reg;
    assign lvl_v[0]  = s1_valid_reg;

    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
        localparam int D      = 1 << gi;
        localparam bit IS_REG = (((gi + 1) % PIPE_EVERY) == 0) || (gi == LEVELS - 1);
        localparam bit HAS_P  = (gi < LEVELS - 1);

        logic [N-1:0] g_c;

        for (genvar bi = 0; bi < N; bi++) begin : g_gbit
            if (bi >= D) begin : g_comb
                assign g_c[bi] = lvl_g[gi][bi] | (lvl_p[gi][bi] & lvl_g[gi][bi-D]);
            end else begin : g_pass
                assign g_c[bi] = lvl_g[gi][bi];
            end
        end

        if (IS_REG) begin : g_reg
            logic [N-1:0] g_reg;
            logic [N-1:0] po_reg;
            logic         c0_reg;
            logic         v_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_reg  <= 1'b0;
                    g_reg  <= '0;
                    po_reg <= '0;
                    c0_reg <= 1'b0;
                end else if (adv) begin
                    v_reg  <= lvl_v[gi];
                    g_reg  <= g_c;
                    po_reg <= lvl_po[gi];
                    c0_reg <= lvl_c0[gi];
                end
            end

            assign lvl_g[gi+1]  = g_reg;
            assign lvl_po[gi+1] = po_reg;
            assign lvl_c0[gi+1] = c0_reg;
            assign lvl_v[gi+1]  = v_reg;
        end else begin : g_wire
            assign lvl_g[gi+1]  = g_c;
            assign lvl_po[gi+1] = lvl_po[gi];
            assign lvl_c0[gi+1] = lvl_c0[gi];
            assign lvl_v[gi+1]  = lvl_v[gi];
        end

        if (HAS_P) begin : g_prop
            logic [N-1:0] p_c;

            for (genvar bi = 0; bi < N; bi++) begin : g_pbit
                if (bi >= D) begin : g_comb
                    assign p_c[bi] = lvl_p[gi][bi] & lvl_p[gi][bi-D];
                end else begin : g_pass
                    assign p_c[bi] = lvl_p[gi][bi];
                end
            end

            if (IS_REG) begin : g_preg
                logic [N-1:0] p_reg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        p_reg <= '0;
                    end else if (adv) begin
                        p_reg <= p_c;
                    end
                end

                assign lvl_p[gi+1] = p_reg;
            end else begin : g_pwire
                assign lvl_p[gi+1] = p_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: carries into each bit, sum, carry out, overflow
    // ------------------------------------------------------------------
    logic [N-1:0] carry_next;
    logic [N-1:0] sum_next;
    logic         cout_next;
    logic         ovf_next;
    logic [N-1:0] sum_reg;
    logic         cout_reg;
    logic         ovf_reg;

    assign carry_next = {lvl_g[LEVELS][N-2:0], lvl_c0[LEVELS]};
    assign sum_next   = lvl_po[LEVELS] ^ carry_next;
    assign cout_next  = lvl_g[LEVELS][N-1];
    assign ovf_next   = carry_next[N-1] ^ cout_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (adv) begin
            out_valid_reg <= lvl_v[LEVELS];
            // Bubbles leave the previous result visible on the outputs.
            if (lvl_v[LEVELS]) begin
                sum_reg  <= sum_next;
                cout_reg <= cout_next;
                ovf_reg  <= ovf_next;
            end
        end
    end

    assign io.sum  = sum_reg;
    assign io.cout = cout_reg;
    assign io.ovf  = ovf_reg;
endmodule

// File: tb/tb_kogge_stone_pipe.sv
// Self-checking bench: directed N=4 and N=16 cases plus randomized streams
// on three width/pipelining configurations against an integer reference model.
module tb_kogge_stone_pipe;
    localparam int NOPS = 10000;

    logic clk = 1'b0;
    logic rst;
    logic rst16;
    logic go_rand = 1'b0;
    logic [2:0] rnd_done = 3'b000;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {ovf, cout, sum} packed at bit positions N+1, N, N-1:0.
    function automatic logic [63:0] model(input int n, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint unsigned mask, ua, ub, bm, r;
        longint sa, sb, sr, half;
        logic ovf;
        mask = (64'd1 << n) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        bm   = sub ? (mask - ub) : ub;
        r    = (ua + bm + (sub ? 64'd1 : 64'(cin))) & ((mask << 1) | 64'd1);
        half = longint'(1) << (n - 1);
        sa   = (ua >= 64'(half)) ? longint'(ua) - 2 * half : longint'(ua);
        sb   = (ub >= 64'(half)) ? longint'(ub) - 2 * half : longint'(ub);
        sr   = sub ? (sa - sb) : (sa + sb + longint'(cin));
        ovf  = (sr > half - 1) || (sr < -half);
        return (64'(ovf) << (n + 1)) | r;
    endfunction

    // ---------------- N=4, PIPE_EVERY=1 ----------------
    kogge_stone_if #(.N(4)) if4();
    kogge_stone_pipe #(.N(4), .PIPE_EVERY(1)) dut4 (.clk(clk), .rst(rst), .io(if4.slave));

    // ---------------- N=16, PIPE_EVERY=2 ----------------
    kogge_stone_if #(.N(16)) if16();
    kogge_stone_pipe #(.N(16), .PIPE_EVERY(2)) dut16 (.clk(clk), .rst(rst16), .io(if16.slave));

    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic cin, input logic sub, input logic [5:0] exp);
        int n;
        @(negedge clk);
        if4.a = a; if4.b = b; if4.cin = cin; if4.sub = sub;
        if4.in_valid = 1'b1; if4.out_ready = 1'b1;
        #1 check({tag, "_rdy"}, 64'(if4.in_ready), 64'd1);
        @(negedge clk);
        if4.in_valid = 1'b0;
        n = 0;
        while (!if4.out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd3);
        check(tag, 64'({if4.ovf, if4.cout, if4.sum}), 64'(exp));
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
        int n;
        logic [63:0] e;
        e = model(16, 32'(a), 32'(b), cin, sub);
        @(negedge clk);
        if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub;
        if16.in_valid = 1'b1; if16.out_ready = 1'b1;
        #1 check({tag, "_rdy"}, 64'(if16.in_ready), 64'd1);
        @(negedge clk);
        if16.in_valid = 1'b0;
        n = 0;
        while (!if16.out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'd3);
        check(tag, 64'({if16.ovf, if16.cout, if16.sum}), e);
    endtask

    // ---------------- randomized configurations ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int NN = (gi == 0) ? 5 : (gi == 1) ? 16 : 32;
        localparam int PE = (gi == 0) ? 1 : (gi == 1) ? 2 : 5;

        kogge_stone_if #(.N(NN)) ifr();
        kogge_stone_pipe #(.N(NN), .PIPE_EVERY(PE)) dut (.clk(clk), .rst(rst), .io(ifr.slave));

        initial begin
            logic [63:0] q[$];
            logic [63:0] e;
            int acc, pop, cyc;
            acc = 0; pop = 0; cyc = 0;
            ifr.in_valid = 1'b0; ifr.out_ready = 1'b0;
            ifr.a = '0; ifr.b = '0; ifr.cin = 1'b0; ifr.sub = 1'b0;
            wait (go_rand);
            while ((acc < NOPS || pop < NOPS) && cyc < 40000) begin
                @(negedge clk);
                cyc++;
                ifr.in_valid  = (acc < NOPS) && ($urandom_range(3) != 0);
                ifr.a         = NN'($urandom);
                ifr.b         = NN'($urandom);
                ifr.cin       = 1'($urandom_range(1));
                ifr.sub       = 1'($urandom_range(1));
                ifr.out_ready = ($urandom_range(3) != 0);
                #1;
                if (ifr.in_valid && ifr.in_ready) begin
                    q.push_back(model(NN, 32'(ifr.a), 32'(ifr.b), ifr.cin, ifr.sub));
                    acc++;
                end
                if (ifr.out_valid && ifr.out_ready) begin
                    e = (q.size() > 0) ? q.pop_front() : 64'hx;
                    check($sformatf("rnd_n%0d", NN), 64'({ifr.ovf, ifr.cout, ifr.sum}), e);
                    pop++;
                end
            end
            check($sformatf("rnd_n%0d_count", NN), 64'(acc + pop), 64'(2 * NOPS));
            check($sformatf("rnd_n%0d_left", NN), 64'(q.size()), 64'd0);
            $display("random N=%0d PIPE_EVERY=%0d: %0d ops in %0d cycles", NN, PE, pop, cyc);
            rnd_done[gi] = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] bq[$];
        logic [63:0] held, e;
        logic stalled;
        int sent, got, c, nstall, n, seen;

        rst = 1'b1; rst16 = 1'b1;
        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.sub = 1'b0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.sub = 1'b0;
        #1;
        check("rst_out_valid", 64'(if4.out_valid), 64'd0);
        check("rst_outputs", 64'({if4.ovf, if4.cout, if4.sum}), 64'd0);
        check("rst_in_ready", 64'(if4.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0; rst16 = 1'b0;

        op4("add_a", 4'b1101, 4'b1011, 1'b0, 1'b0, 6'b01_1000);
        op4("add_b", 4'b0110, 4'b1001, 1'b0, 1'b0, 6'b00_1111);
        op4("add_c", 4'b1111, 4'b0001, 1'b0, 1'b0, 6'b01_0000);
        op4("add_cin", 4'b0001, 4'b0001, 1'b1, 1'b0, 6'b00_0011);
        op4("sub_a", 4'b0101, 4'b0011, 1'b0, 1'b1, 6'b01_0010);
        op4("sub_b", 4'b0011, 4'b0101, 1'b0, 1'b1, 6'b00_1110);
        op4("sub_c", 4'b1000, 4'b0001, 1'b0, 1'b1, 6'b11_0111);
        op4("sub_a_cin", 4'b0101, 4'b0011, 1'b1, 1'b1, 6'b01_0010);
        op4("sub_b_cin", 4'b0011, 4'b0101, 1'b1, 1'b1, 6'b00_1110);
        op4("sub_c_cin", 4'b1000, 4'b0001, 1'b1, 1'b1, 6'b11_0111);
        op4("ovf_a", 4'b0111, 4'b0001, 1'b0, 1'b0, 6'b10_1000);
        op4("ovf_b", 4'b1000, 4'b1000, 1'b0, 1'b0, 6'b11_0000);

        // Backpressure: 8 ops streamed, out_ready low for 5 cycles mid-stream.
        sent = 0; got = 0; c = 0; nstall = 0; stalled = 1'b0; held = '0;
        while (got < 8 && c < 60) begin
            @(negedge clk);
            if (stalled) check("bp_hold", 64'({if16.ovf, if16.cout, if16.sum}), held);
            if16.in_valid  = (sent < 8);
            if16.a         = 16'($urandom);
            if16.b         = 16'($urandom);
            if16.cin       = 1'($urandom_range(1));
            if16.sub       = 1'($urandom_range(1));
            if16.out_ready = !(c >= 4 && c < 9);
            #1;
            stalled = if16.out_valid && !if16.out_ready;
            if (stalled) begin
                nstall++;
                held = 64'({if16.ovf, if16.cout, if16.sum});
                check("bp_in_ready", 64'(if16.in_ready), 64'd0);
            end
            if (if16.in_valid && if16.in_ready) begin
                bq.push_back(model(16, 32'(if16.a), 32'(if16.b), if16.cin, if16.sub));
                sent++;
            end
            if (if16.out_valid && if16.out_ready) begin
                e = (bq.size() > 0) ? bq.pop_front() : 64'hx;
                check("bp_data", 64'({if16.ovf, if16.cout, if16.sum}), e);
                got++;
            end
            c++;
        end
        if16.in_valid = 1'b0;
        check("bp_count", 64'(got), 64'd8);
        check("bp_stall_cycles", 64'(nstall), 64'd5);
        $display("backpressure: %0d results in %0d cycles, %0d stalled", got, c, nstall);

        // Reset with 3 ops in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if16.a = 16'($urandom); if16.b = 16'($urandom);
            if16.in_valid = 1'b1; if16.out_ready = 1'b0;
            #1 check("rs_accept", 64'(if16.in_ready), 64'd1);
        end
        @(negedge clk);
        if16.in_valid = 1'b0;
        n = 0;
        while (!if16.out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("rs_filled", 64'(if16.out_valid), 64'd1);
        #2 rst16 = 1'b1;
        #1;
        check("rs_out_valid", 64'(if16.out_valid), 64'd0);
        check("rs_outputs", 64'({if16.ovf, if16.cout, if16.sum}), 64'd0);
        @(negedge clk);
        rst16 = 1'b0;
        if16.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if16.out_valid) seen++;
        end
        check("rs_no_ghosts", 64'(seen), 64'd0);
        op16("rs_after", 16'h7fff, 16'h0001, 1'b0, 1'b0);
        op16("rs_after_sub", 16'h1234, 16'h4321, 1'b1, 1'b1);
        $display("reset mid-stream: flushed, next op latency checked");

        go_rand = 1'b1;
        n = 0;
        while (rnd_done != 3'b111 && n < 50000) begin
            @(negedge clk);
            n++;
        end
        check("rnd_finished", 64'(rnd_done), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
